// File: rtl/fb_pixel_writer.sv
// ============================================================================
// fb_pixel_writer : read-modify-write pixel plotter and full-frame clear
//                   engine for a 4bpp, 8-pixels-per-word frame buffer.
// Revision 1.0
// ============================================================================
`default_nettype none

module fb_pixel_writer #(
  parameter int H_PIXELS       = 640,
  parameter int V_LINES        = 480,
  parameter int WORDS_PER_LINE = 80,
  parameter int RD_LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_x,
  input  logic [8:0]  req_y,
  input  logic [3:0]  req_color,
  input  logic        clear_start,
  input  logic [3:0]  clear_color,
  output logic        busy,
  output logic [17:0] mem_address,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data
);

  localparam logic [9:0]  X_LIMIT   = 10'(H_PIXELS);
  localparam logic [8:0]  Y_LIMIT   = 9'(V_LINES);
  localparam logic [17:0] LAST_ADDR = 18'(V_LINES * WORDS_PER_LINE - 1);
  localparam logic [2:0]  LAT_LAST  = 3'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t      r_state;
  logic [2:0]  r_pix;
  logic [3:0]  r_color;
  logic [2:0]  r_wait_cnt;

  logic [17:0] w_row_base;
  logic [17:0] w_addr;
  logic [4:0]  w_shift;
  logic [31:0] w_merged;
  logic        w_in_range;

  // y*80 built from two shifts so no multiplier is inferred
  assign w_row_base = ({9'd0, req_y} << 6) + ({9'd0, req_y} << 4);
  assign w_addr     = w_row_base + {11'd0, req_x[9:3]};
  assign w_in_range = (req_x < X_LIMIT) && (req_y < Y_LIMIT);

  assign w_shift  = {r_pix, 2'b00};
  assign w_merged = (mem_rd_data & ~(32'hF << w_shift)) | ({28'd0, r_color} << w_shift);

  assign req_ready = (r_state == S_IDLE) && !clear_start && !reset;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pix       <= 3'd0;
      r_color     <= 4'd0;
      r_wait_cnt  <= 3'd0;
      mem_address <= 18'd0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_start) begin
            mem_address <= 18'd0;
            mem_wr_data <= {8{clear_color}};
            mem_wr_en   <= 1'b1;
            r_state     <= S_CLEAR;
          end else if (req_valid && w_in_range) begin
            // out-of-range requests are consumed here with no memory access
            r_pix       <= req_x[2:0];
            r_color     <= req_color;
            mem_address <= w_addr;
            mem_rd_en   <= 1'b1;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          mem_rd_en  <= 1'b0;
          r_wait_cnt <= 3'd0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == LAT_LAST) begin
            mem_wr_data <= w_merged;
            mem_wr_en   <= 1'b1;
            r_state     <= S_WRITE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
        S_WRITE: begin
          mem_wr_en <= 1'b0;
          r_state   <= S_IDLE;
        end
        S_CLEAR: begin
          if (mem_address == LAST_ADDR) begin
            mem_wr_en <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            mem_address <= mem_address + 18'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
// ============================================================================
// tb_fb_pixel_writer : scoreboard bench for fb_pixel_writer (latency 1 and 3).
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fb_pixel_writer;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int WORDS = 38400;

  int errors = 0;
  int checks = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- instance A (RD_LATENCY = 1) ----------------
  logic        reset, req_valid, req_ready, clear_start, busy;
  logic [9:0]  req_x;
  logic [8:0]  req_y;
  logic [3:0]  req_color, clear_color;
  logic [17:0] mem_address;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_rd_data, mem_wr_data;

  fb_pixel_writer #(.RD_LATENCY(LAT_A)) u_dut_a (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .clear_start(clear_start), .clear_color(clear_color), .busy(busy),
    .mem_address(mem_address), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  // ---------------- instance B (RD_LATENCY = 3) ----------------
  logic        b_reset, b_req_valid, b_req_ready, b_busy;
  logic [9:0]  b_req_x;
  logic [8:0]  b_req_y;
  logic [3:0]  b_req_color;
  logic [17:0] b_mem_address;
  logic        b_mem_rd_en, b_mem_wr_en;
  logic [31:0] b_mem_rd_data, b_mem_wr_data;

  fb_pixel_writer #(.RD_LATENCY(LAT_B)) u_dut_b (
    .clock(clock), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_x(b_req_x), .req_y(b_req_y), .req_color(b_req_color),
    .clear_start(1'b0), .clear_color(4'd0), .busy(b_busy),
    .mem_address(b_mem_address), .mem_rd_en(b_mem_rd_en), .mem_rd_data(b_mem_rd_data),
    .mem_wr_en(b_mem_wr_en), .mem_wr_data(b_mem_wr_data)
  );

  // ---------------- memory models ----------------
  logic [31:0] ram [WORDS];
  logic [31:0] refmem [WORDS];
  logic        init_done = 1'b0;
  logic        pre_en = 1'b0;
  logic [17:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] a_pipe [LAT_A];
  logic [31:0] b_pipe [LAT_B];

  function automatic logic [31:0] seed_word(input int a);
    return 32'(a) * 32'h9E3779B9 ^ 32'h0F1E2D3C;
  endfunction

  function automatic logic [31:0] b_word(input logic [17:0] a);
    return {14'd0, a} * 32'h01010101 ^ 32'hA5A5A5A5;
  endfunction

  always @(posedge clock) begin
    if (!init_done) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= seed_word(i);
      init_done <= 1'b1;
    end else if (pre_en) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_wr_en && !reset && mem_address < 18'(WORDS)) begin
      ram[mem_address] <= mem_wr_data;
    end
    a_pipe[0] <= (mem_address < 18'(WORDS)) ? ram[mem_address] : 32'hDEADBEEF;
    for (int i = 1; i < LAT_A; i++) a_pipe[i] <= a_pipe[i-1];
    b_pipe[0] <= b_word(b_mem_address);
    for (int i = 1; i < LAT_B; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign mem_rd_data   = a_pipe[LAT_A-1];
  assign b_mem_rd_data = b_pipe[LAT_B-1];

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pixel-by-pixel replacement of one colour index in a packed word
  function automatic logic [31:0] merge(input logic [31:0] w, input int pix, input int c);
    logic [31:0] r;
    for (int k = 0; k < 8; k++)
      r[4*k +: 4] = (k == pix) ? 4'(c) : w[4*k +: 4];
    return r;
  endfunction

  logic [17:0] rdq[$];
  logic [17:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [31:0] bq_data[$];
  logic [17:0] bq_addr[$];

  always @(negedge clock) begin
    if (!reset && init_done) begin
      if (mem_rd_en && mem_wr_en) chk("a_rd_wr_overlap", 1, 0);
      if (mem_rd_en) begin
        if (rdq.size() == 0) chk("a_unexpected_read", {46'd0, mem_address}, 64'hFFFFFFFF);
        else chk("a_read_addr", {46'd0, mem_address}, {46'd0, rdq.pop_front()});
      end
      if (mem_wr_en) begin
        if (wq_addr.size() == 0) chk("a_unexpected_write", {46'd0, mem_address}, 64'hFFFFFFFF);
        else begin
          chk("a_write_addr", {46'd0, mem_address}, {46'd0, wq_addr.pop_front()});
          chk("a_write_data", {32'd0, mem_wr_data}, {32'd0, wq_data.pop_front()});
        end
      end
    end
    if (b_mem_rd_en && b_mem_wr_en) chk("b_rd_wr_overlap", 1, 0);
    if (b_mem_wr_en) begin
      if (bq_addr.size() == 0) chk("b_unexpected_write", {46'd0, b_mem_address}, 64'hFFFFFFFF);
      else begin
        chk("b_write_addr", {46'd0, b_mem_address}, {46'd0, bq_addr.pop_front()});
        chk("b_write_data", {32'd0, b_mem_wr_data}, {32'd0, bq_data.pop_front()});
      end
    end
  end

  // ---------------- stimulus helpers (all entered and left at a negedge) ----------------
  task automatic preload(input int a, input logic [31:0] d);
    pre_addr = 18'(a); pre_data = d; pre_en = 1'b1;
    refmem[a] = d;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  task automatic plot(input int x, input int y, input int c);
    int lows;
    bit inr;
    int a;
    inr = (x < 640) && (y < 480);
    req_x = 10'(x); req_y = 9'(y); req_color = 4'(c); req_valid = 1'b1;
    chk("ready_at_offer", {63'd0, req_ready}, 1);
    if (inr) begin
      a = y * 80 + x / 8;
      rdq.push_back(18'(a));
      wq_addr.push_back(18'(a));
      wq_data.push_back(merge(refmem[a], x % 8, c));
      refmem[a] = merge(refmem[a], x % 8, c);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_x = 10'($urandom); req_y = 9'($urandom); req_color = 4'($urandom);
    @(negedge clock);
    lows = 0;
    while (!req_ready && lows < 50) begin
      lows++;
      @(negedge clock);
    end
    chk("ready_gap", 64'(lows), inr ? 64'(2 + LAT_A) : 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    for (int i = 0; i < WORDS; i++) refmem[i] = seed_word(i);
    reset = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; req_color = '0;
    clear_start = 1'b0; clear_color = '0;
    b_reset = 1'b1; b_req_valid = 1'b0; b_req_x = '0; b_req_y = '0; b_req_color = '0;
    repeat (3) @(negedge clock);
    chk("reset_ready", {63'd0, req_ready}, 0);
    chk("reset_busy", {63'd0, busy}, 0);
    chk("reset_addr", {46'd0, mem_address}, 0);
    chk("reset_strobes", {62'd0, mem_rd_en, mem_wr_en}, 0);
    chk("reset_wdata", {32'd0, mem_wr_data}, 0);
    reset = 1'b0; b_reset = 1'b0;
    #1;
    chk("ready_after_reset", {63'd0, req_ready}, 1);
    @(negedge clock);

    // directed plots
    preload(161, 32'h12345678);
    plot(13, 2, 4'hA);
    chk("ram_161", {32'd0, ram[161]}, 64'h12A45678);
    preload(38399, 32'h00000000);
    plot(639, 479, 4'hF);
    chk("ram_38399", {32'd0, ram[38399]}, 64'hF0000000);
    preload(0, 32'hFFFFFFFF);
    plot(0, 0, 4'h3);
    chk("ram_0", {32'd0, ram[0]}, 64'hFFFFFFF3);
    plot(640, 0, 4'h1);
    plot(0, 480, 4'h2);

    // back-to-back plots into one word
    preload(0, 32'h00000000);
    for (int i = 0; i < 4; i++) plot(i, 0, i + 1);
    chk("ram_0_b2b", {32'd0, ram[0]}, 64'h00004321);

    // random plots, some outside the frame
    for (int i = 0; i < 40; i++)
      plot($urandom_range(0, 700), $urandom_range(0, 511), $urandom_range(0, 15));

    // full clear with a competing request; mid-clear restart must be ignored
    clear_start = 1'b1; clear_color = 4'h5;
    req_valid = 1'b1; req_x = 10'd7; req_y = 9'd7; req_color = 4'h9;
    #1;
    chk("ready_during_clear_start", {63'd0, req_ready}, 0);
    for (int i = 0; i < WORDS; i++) begin
      wq_addr.push_back(18'(i));
      wq_data.push_back(32'h55555555);
      refmem[i] = 32'h55555555;
    end
    @(posedge clock);
    #1;
    clear_start = 1'b0; req_valid = 1'b0;
    @(negedge clock);
    n = 0;
    while (busy && n < 40000) begin
      chk("ready_low_in_clear", {63'd0, req_ready}, 0);
      n++;
      clear_start = (n == 100);
      clear_color = 4'h9;
      @(negedge clock);
    end
    clear_start = 1'b0;
    chk("clear_busy_cycles", 64'(n), 64'(WORDS));
    chk("clear_writes_left", 64'(wq_addr.size()), 0);

    for (int i = 0; i < 10; i++)
      plot($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 15));

    // latency-3 instance: reset while waiting for read data
    b_req_x = 10'd5; b_req_y = 9'd1; b_req_color = 4'h7; b_req_valid = 1'b1;
    @(posedge clock);
    #1;
    b_req_valid = 1'b0;
    @(posedge clock);
    #3;
    b_reset = 1'b1;
    #1;
    chk("b_reset_ready", {63'd0, b_req_ready}, 0);
    chk("b_reset_busy", {63'd0, b_busy}, 0);
    chk("b_reset_strobes", {62'd0, b_mem_rd_en, b_mem_wr_en}, 0);
    chk("b_reset_addr", {46'd0, b_mem_address}, 0);
    chk("b_reset_wdata", {32'd0, b_mem_wr_data}, 0);
    repeat (6) @(negedge clock);
    b_reset = 1'b0;
    @(negedge clock);
    chk("b_ready_after_reset", {63'd0, b_req_ready}, 1);
    b_req_x = 10'd9; b_req_y = 9'd3; b_req_color = 4'hC; b_req_valid = 1'b1;
    bq_addr.push_back(18'd241);
    bq_data.push_back(merge(b_word(18'd241), 1, 4'hC));
    @(posedge clock);
    #1;
    b_req_valid = 1'b0;
    b_req_x = 10'd600; b_req_y = 9'd400; b_req_color = 4'h1;
    @(negedge clock);
    n = 0;
    while (!b_req_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("b_ready_gap", 64'(n), 64'(2 + LAT_B));

    repeat (10) @(negedge clock);
    chk("a_reads_left", 64'(rdq.size()), 0);
    chk("a_writes_left", 64'(wq_addr.size()), 0);
    chk("b_writes_left", 64'(bq_addr.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
